// File: rtl/fc_g0_mac.sv
// Q8.8 fully-connected MAC for layer g0: one neuron per 16 RUN + 3 DRAIN cycles, result registered on the last DRAIN cycle.
// Output is valid/ready; while out_ready is low the result holds and no new addresses are issued.
module fc_g0_mac #(
  parameter int N_IN  = 32,
  parameter int N_OUT = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40,
  parameter int RELU  = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [8:0]  w_addr_a,
  output logic [8:0]  w_addr_b,
  input  logic [15:0] w_q_a,
  input  logic [15:0] w_q_b,
  output logic [4:0]  act_addr_a,
  output logic [4:0]  act_addr_b,
  input  logic [15:0] act_q_a,
  input  logic [15:0] act_q_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [3:0]  out_index
);

  localparam int KW = $clog2(N_IN / 2);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, DONE} state_t;

  state_t                   state, state_nx;
  logic [3:0]               j;
  logic [KW-1:0]            k;
  logic                     v1, v2;
  logic signed [31:0]       p_a, p_b;
  logic signed [ACC_W-1:0]  acc, acc_sh, pa_x, pb_x;
  logic [15:0]              sat;
  logic                     run, k_last, j_last, drain_last, hs;

  assign run        = (state == RUN);
  assign k_last     = (int'(k) == N_IN / 2 - 1);
  assign j_last     = (int'(j) == N_OUT - 1);
  assign drain_last = (int'(k) == 2);
  assign hs         = out_valid & out_ready;

  assign w_addr_a   = run ? 9'(int'(j) * N_IN + 2 * int'(k)) : '0;
  assign w_addr_b   = run ? 9'(int'(j) * N_IN + 2 * int'(k) + 1) : '0;
  assign act_addr_a = run ? 5'(2 * int'(k)) : '0;
  assign act_addr_b = run ? 5'(2 * int'(k) + 1) : '0;

  assign pa_x   = {{(ACC_W-32){p_a[31]}}, p_a};
  assign pb_x   = {{(ACC_W-32){p_b[31]}}, p_b};
  assign acc_sh = acc >>> FRAC;

  always_comb begin
    sat = acc_sh[15:0];
    if (acc_sh > SAT_MAX)      sat = 16'h7FFF;
    else if (acc_sh < SAT_MIN) sat = 16'h8000;
    if (RELU != 0 && sat[15])  sat = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN:   begin busy = 1'b1; if (k_last) state_nx = DRAIN; end
      DRAIN: begin busy = 1'b1; if (drain_last) state_nx = OUT; end
      OUT:   begin busy = 1'b1; if (hs) state_nx = j_last ? DONE : RUN; end
      DONE:  begin done = 1'b1; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  // v1 marks the memory-data cycle, v2 the product-valid cycle of the pipeline.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      j         <= '0;
      k         <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      p_a       <= '0;
      p_b       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      v1 <= run;
      v2 <= v1;
      if (v1) begin
        p_a <= $signed({{16{w_q_a[15]}}, w_q_a}) * $signed({{16{act_q_a[15]}}, act_q_a});
        p_b <= $signed({{16{w_q_b[15]}}, w_q_b}) * $signed({{16{act_q_b[15]}}, act_q_b});
      end
      if (v2) acc <= acc + pa_x + pb_x;
      case (state)
        IDLE: if (start) begin
          j   <= '0;
          k   <= '0;
          acc <= '0;
        end
        RUN: k <= k_last ? '0 : k + 1'b1;
        DRAIN: begin
          if (drain_last) begin
            k         <= '0;
            out_data  <= sat;
            out_index <= j;
            out_valid <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: if (hs) begin
          out_valid <= 1'b0;
          if (!j_last) begin
            j   <= j + 1'b1;
            k   <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_g0_mac.sv
// Bench for fc_g0_mac: ROM/activation models, a dot-product reference and a cycle timeline built from the layer timing rules.
module tb_fc_g0_mac;

  localparam int MAXC = 400;

  logic        clock = 1'b0;
  logic        reset_n, start, out_ready;
  logic        busy, done, out_valid;
  logic [8:0]  w_addr_a, w_addr_b;
  logic [4:0]  act_addr_a, act_addr_b;
  logic [15:0] w_q_a, w_q_b, act_q_a, act_q_b, out_data;
  logic [3:0]  out_index;

  logic        r_busy, r_done, r_out_valid;
  logic [8:0]  r_w_addr_a, r_w_addr_b;
  logic [4:0]  r_act_addr_a, r_act_addr_b;
  logic [15:0] r_w_q_a, r_w_q_b, r_act_q_a, r_act_q_b, r_out_data;
  logic [3:0]  r_out_index;

  logic [15:0] rom [512];
  logic [15:0] act [32];
  logic [15:0] exp_d [2][16];
  int          run_n [MAXC];
  int          run_k [MAXC];
  int          ov_n  [MAXC];
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  fc_g0_mac #(.RELU(0)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .w_addr_a(w_addr_a), .w_addr_b(w_addr_b), .w_q_a(w_q_a), .w_q_b(w_q_b),
    .act_addr_a(act_addr_a), .act_addr_b(act_addr_b), .act_q_a(act_q_a), .act_q_b(act_q_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index)
  );

  fc_g0_mac #(.RELU(1)) u_relu (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(r_busy), .done(r_done),
    .w_addr_a(r_w_addr_a), .w_addr_b(r_w_addr_b), .w_q_a(r_w_q_a), .w_q_b(r_w_q_b),
    .act_addr_a(r_act_addr_a), .act_addr_b(r_act_addr_b), .act_q_a(r_act_q_a), .act_q_b(r_act_q_b),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data), .out_index(r_out_index)
  );

  // Synchronous-read memories, one cycle of latency.
  always @(posedge clock) begin
    w_q_a     <= rom[w_addr_a];
    w_q_b     <= rom[w_addr_b];
    act_q_a   <= act[act_addr_a];
    act_q_b   <= act[act_addr_b];
    r_w_q_a   <= rom[r_w_addr_a];
    r_w_q_b   <= rom[r_w_addr_b];
    r_act_q_a <= act[r_act_addr_a];
    r_act_q_b <= act[r_act_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] model(input int n, input bit relu);
    longint sum = 0;
    longint q;
    for (int i = 0; i < 32; i++)
      sum += longint'($signed(rom[n*32+i])) * longint'($signed(act[i]));
    q = sum >>> 8;
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
    if (relu && q < 0) q = 0;
    return 16'(q);
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_out_index"}, 32'(out_index), 0);
    chk({tag, "_w_addr_a"}, 32'(w_addr_a), 0);
    chk({tag, "_w_addr_b"}, 32'(w_addr_b), 0);
    chk({tag, "_act_addr_a"}, 32'(act_addr_a), 0);
    chk({tag, "_act_addr_b"}, 32'(act_addr_b), 0);
    chk({tag, "_relu_out_data"}, 32'(r_out_data), 0);
  endtask

  // Full layer pass; stall_n >= 0 holds out_ready low stall_len cycles on that neuron,
  // abort_cyc > 0 asserts reset in that cycle and leaves it asserted.
  task automatic run_pass(input int stall_n, input int stall_len, input bit extra, input int abort_cyc);
    int rs, ovs, stall_ovs, done_cyc, results, dones, nv, rn;
    results   = 0;
    dones     = 0;
    stall_ovs = 20 + 20 * stall_n;
    for (int n = 0; n < 16; n++) begin
      exp_d[0][n] = model(n, 1'b0);
      exp_d[1][n] = model(n, 1'b1);
    end
    for (int c = 0; c < MAXC; c++) begin
      run_n[c] = -1;
      run_k[c] = 0;
      ov_n[c]  = -1;
    end
    for (int n = 0; n < 16; n++) begin
      rs = 1 + 20 * n + ((stall_n >= 0 && n > stall_n) ? stall_len : 0);
      for (int c = 0; c < 16; c++) begin
        run_n[rs+c] = n;
        run_k[rs+c] = c;
      end
      ovs = rs + 19;
      for (int c = 0; c <= ((n == stall_n) ? stall_len : 0); c++) ov_n[ovs+c] = n;
    end
    done_cyc = 321 + ((stall_n >= 0) ? stall_len : 0);

    @(posedge clock); #1;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
      @(negedge clock);
      nv = ov_n[cyc];
      rn = run_n[cyc];
      chk("busy", 32'(busy), 32'(cyc < done_cyc));
      chk("done", 32'(done), 32'(cyc == done_cyc));
      chk("w_addr_a", 32'(w_addr_a), (rn >= 0) ? rn * 32 + 2 * run_k[cyc] : 0);
      chk("w_addr_b", 32'(w_addr_b), (rn >= 0) ? rn * 32 + 2 * run_k[cyc] + 1 : 0);
      chk("act_addr_a", 32'(act_addr_a), (rn >= 0) ? 2 * run_k[cyc] : 0);
      chk("act_addr_b", 32'(act_addr_b), (rn >= 0) ? 2 * run_k[cyc] + 1 : 0);
      chk("out_valid", 32'(out_valid), 32'(nv >= 0));
      chk("relu_out_valid", 32'(r_out_valid), 32'(nv >= 0));
      if (nv >= 0) begin
        chk("out_data", 32'(out_data), 32'(exp_d[0][nv]));
        chk("out_index", 32'(out_index), nv);
        chk("relu_out_data", 32'(r_out_data), 32'(exp_d[1][nv]));
      end
      if (out_valid && out_ready) results++;
      if (done) dones++;
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        reset_n = 1'b0;
        #1;
        check_zero_outputs("abort");
        return;
      end
      @(posedge clock); #1;
      start     = extra && (cyc + 1 == 5 || cyc + 1 == 20 || cyc + 1 == 150);
      out_ready = !(stall_n >= 0 && cyc + 1 >= stall_ovs && cyc + 1 < stall_ovs + stall_len);
    end
    chk("result_count", results, 16);
    chk("done_count", dones, 1);
  endtask

  initial begin
    reset_n   = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 512; i++) rom[i] = 16'h0100;
    for (int i = 0; i < 32; i++)  act[i] = 16'h0100;
    #2 reset_n = 1'b0;
    #1 check_zero_outputs("reset");
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;

    // All 1.0 weights and activations: every neuron yields 32.0.
    run_pass(-1, 0, 1'b0, 0);
    chk("basic_value", 32'(exp_d[0][7]), 32'h2000);

    // Address sweep: w[n] = n, acts = 1 LSB.
    for (int i = 0; i < 512; i++) rom[i] = 16'(i);
    for (int i = 0; i < 32; i++)  act[i] = 16'h0001;
    run_pass(-1, 0, 1'b0, 0);

    // Positive saturation.
    for (int i = 0; i < 512; i++) rom[i] = 16'h7FFF;
    for (int i = 0; i < 32; i++)  act[i] = 16'h7FFF;
    run_pass(-1, 0, 1'b0, 0);

    // Negative result: -1.0 * 1.0 summed; ReLU instance clamps to zero.
    for (int i = 0; i < 512; i++) rom[i] = 16'hFF00;
    for (int i = 0; i < 32; i++)  act[i] = 16'h0100;
    run_pass(-1, 0, 1'b0, 0);

    // Random small-magnitude data with backpressure on neuron 3.
    for (int i = 0; i < 512; i++) rom[i] = 16'($urandom_range(0, 1023)) - 16'd512;
    for (int i = 0; i < 32; i++)  act[i] = 16'($urandom_range(0, 1023)) - 16'd512;
    run_pass(3, 7, 1'b0, 0);

    // Full-range random data with stray start pulses while busy.
    for (int i = 0; i < 512; i++) rom[i] = 16'($urandom);
    for (int i = 0; i < 32; i++)  act[i] = 16'($urandom);
    run_pass(-1, 0, 1'b1, 0);

    // Reset during neuron 5 RUN, then a fresh pass on new random data.
    for (int i = 0; i < 512; i++) rom[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
    for (int i = 0; i < 32; i++)  act[i] = 16'($urandom_range(0, 511)) - 16'd256;
    run_pass(-1, 0, 1'b0, 106);
    start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero_outputs("held_reset");
    reset_n = 1'b1;
    run_pass(-1, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
